// File: rtl/shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// shift_reg_pkg
//   Shared types and helpers for the shift-register family of blocks.
//   - piso_state_t    : FSM states of the parallel-in / serial-out serializer.
//   - piso_cnt_width  : width of the serializer's bit counter for an N-bit
//                       word, max(1, clog2(N)). A one-bit word still needs a
//                       one-bit counter so that the zero flag has a register
//                       to come from.
// ---------------------------------------------------------------------------
package shift_reg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  function automatic int piso_cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/n_bit_piso_serializer_if.sv
// ---------------------------------------------------------------------------
// n_bit_piso_serializer_if
//   Bundles the word-side handshake and the bit-side serial outputs of the
//   serializer.
//
//   Handshake: a word transfers on a rising clock edge where
//   in_valid && in_ready are both 1. in_valid may rise regardless of
//   in_ready and must then stay asserted, with in_data stable, until that
//   edge. in_data is ignored on every other edge. in_ready may depend
//   combinationally on shift_en, but never on in_valid.
//
//   Signals:
//     in_valid  : word on in_data is offered.
//     in_data   : N-bit word to serialise.
//     in_ready  : serializer can take a word on this edge.
//     ser_out   : current serial bit.
//     ser_valid : ser_out carries a word bit.
//     ser_first : ser_out is the first bit of a word.
//     ser_last  : ser_out is the last bit of a word.
//     dbg_state : current FSM state, for observation only.
//
//   Modports: master = word producer / bit consumer, slave = serializer.
// ---------------------------------------------------------------------------
interface n_bit_piso_serializer_if #(
  parameter int N = 8
);
  import shift_reg_pkg::*;

  logic        in_valid;
  logic [N-1:0] in_data;
  logic        in_ready;
  logic        ser_out;
  logic        ser_valid;
  logic        ser_first;
  logic        ser_last;
  piso_state_t dbg_state;

  modport master (
    output in_valid, in_data,
    input  in_ready, ser_out, ser_valid, ser_first, ser_last, dbg_state
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_out, ser_valid, ser_first, ser_last, dbg_state
  );

endinterface

// File: rtl/piso_bit_counter.sv
// ---------------------------------------------------------------------------
// piso_bit_counter
//   Loadable down-counter with enable and a zero flag. It tracks how many
//   bits of the current word remain after the one being shown.
//
//   Ports:
//     clk        : rising-edge clock.
//     rst        : asynchronous active-low reset, clears the count.
//     load_i     : load load_val_i on this edge (has priority over dec_i).
//     load_val_i : value to load.
//     dec_i      : decrement on this edge; saturates at zero.
//     count_o    : current count.
//     zero_o     : count_o == 0.
// ---------------------------------------------------------------------------
module piso_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      // Guarding on non-zero keeps the count from wrapping to all ones.
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/n_bit_piso_serializer.sv
// ---------------------------------------------------------------------------
// n_bit_piso_serializer
//   Parallel-in, serial-out shift register. Takes an N-bit word over a
//   valid/ready handshake and emits it one bit per shift_en edge, with
//   first/last framing strobes. Words can follow each other with no gap:
//   the next word is accepted on the same edge that retires the last bit.
//
//   Parameters:
//     N         : word width, N >= 1.
//     MSB_FIRST : 1 = bit N-1 goes out first, 0 = bit 0 goes out first.
//
//   Ports:
//     clk      : rising-edge clock.
//     rst      : asynchronous active-low reset; discards any word in flight.
//     shift_en : bit-rate enable; the serial stream advances only on edges
//                where this is 1. Word acceptance in IDLE ignores it.
//     bus      : handshake and serial outputs (slave modport).
// ---------------------------------------------------------------------------
module n_bit_piso_serializer
  import shift_reg_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift_en,
  n_bit_piso_serializer_if.slave  bus
);

  localparam int            CW       = piso_cnt_width(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  piso_state_t  state_q;
  piso_state_t  state_d;
  logic [N-1:0] sr_q;
  logic [N-1:0] sr_d;

  logic          cnt_load;
  logic          cnt_dec;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic          in_ready;
  logic          out_bit;

  // Counter holds "bits remaining after the current one": N-1 on the first
  // bit, 0 on the last.
  piso_bit_counter #(
    .W (CW)
  ) u_bit_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (LAST_IDX),
    .dec_i      (cnt_dec),
    .count_o    (cnt),
    .zero_o     (cnt_zero)
  );

  // In SHIFT a new word can only land on the edge that retires the last
  // bit, which is why readiness follows shift_en combinationally there.
  assign in_ready = rst && ((state_q == IDLE) || (cnt_zero && shift_en));

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d     = bus.in_data;
          cnt_load = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (!cnt_zero) begin
            // Move the next bit toward the output end.
            sr_d    = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
            cnt_dec = 1'b1;
          end else if (bus.in_valid) begin
            sr_d     = bus.in_data;
            cnt_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
    end
  end

  assign out_bit = MSB_FIRST ? sr_q[N-1] : sr_q[0];

  // Serial outputs are qualified by SHIFT so stale register contents never
  // show while idle.
  assign bus.ser_valid = (state_q == SHIFT);
  assign bus.ser_out   = (state_q == SHIFT) && out_bit;
  assign bus.ser_first = (state_q == SHIFT) && (cnt == LAST_IDX);
  assign bus.ser_last  = (state_q == SHIFT) && cnt_zero;
  assign bus.in_ready  = in_ready;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_n_bit_piso_serializer.sv
`timescale 1ns/1ps
module tb_n_bit_piso_serializer;
  import shift_reg_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic sen_m;
  logic sen_l;
  logic sen_1;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  n_bit_piso_serializer_if #(.N(8)) bm ();
  n_bit_piso_serializer_if #(.N(8)) bl ();
  n_bit_piso_serializer_if #(.N(1)) b1 ();

  n_bit_piso_serializer #(.N(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .shift_en(sen_m), .bus(bm.slave)
  );
  n_bit_piso_serializer #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .shift_en(sen_l), .bus(bl.slave)
  );
  n_bit_piso_serializer #(.N(1), .MSB_FIRST(1'b1)) u_n1 (
    .clk(clk), .rst(rst), .shift_en(sen_1), .bus(b1.slave)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (MSB-first, N=8 instance) ----------------
  // The word in flight is a queue of bits still to be shown, front = current.
  logic m_q[$];

  function automatic void m_load(input logic [7:0] w);
    m_q.delete();
    for (int i = 7; i >= 0; i--) m_q.push_back(w[i]);
  endfunction

  // Expected {ser_valid, ser_out, ser_first, ser_last, in_ready}.
  function automatic logic [4:0] m_expect(input logic s);
    if (m_q.size() == 0) return 5'b00001;
    return {1'b1, m_q[0], (m_q.size() == 8), (m_q.size() == 1),
            (m_q.size() == 1) && s};
  endfunction

  function automatic logic [4:0] m_mask(input logic [4:0] e);
    return e[4] ? 5'b11111 : 5'b10001;
  endfunction

  function automatic void m_edge(input logic v, input logic [7:0] d, input logic s);
    logic rdy;
    rdy = (m_q.size() == 0) || ((m_q.size() == 1) && s);
    if (v && rdy) m_load(d);
    else if (s && (m_q.size() > 0)) void'(m_q.pop_front());
  endfunction

  // ---------------- driver ----------------
  task automatic drive_main(input logic v, input logic [7:0] d, input logic s);
    @(negedge clk);
    bm.in_valid = v;
    bm.in_data  = d;
    sen_m       = s;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [4:0] got;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    got = {bm.ser_valid, bm.ser_out, bm.ser_first, bm.ser_last, bm.in_ready};
    checks++;
    if (got !== 5'b00000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000", got);
    end
    checks++;
    if (bm.dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=%0d", bm.dbg_state, IDLE);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    got = {bm.in_ready, bl.in_ready, b1.in_ready, bm.ser_valid, bl.ser_valid};
    checks++;
    if (got !== 5'b11100) begin
      failures++;
      $display("FAIL reset_release ready/valid got=%b exp=11100", got);
    end
    m_q.delete();
  endtask

  task automatic test_single_a5();
    logic [4:0] got, exp;
    logic [7:0] obs;
    int nvalid;
    obs = '0;
    nvalid = 0;
    for (int i = 0; i < 11; i++) begin
      drive_main(i == 0, (i == 0) ? 8'hA5 : 8'($urandom), 1'b1);
      got = {bm.ser_valid, bm.ser_out, bm.ser_first, bm.ser_last, bm.in_ready};
      exp = m_expect(sen_m);
      checks++;
      if ((got & m_mask(exp)) !== exp) begin
        failures++;
        $display("FAIL single_a5 cyc=%0d got(v,o,f,l,r)=%b exp=%b", i, got, exp);
      end
      if (bm.ser_valid === 1'b1) begin
        obs = {obs[6:0], bm.ser_out};
        nvalid++;
      end
      m_edge(bm.in_valid, bm.in_data, sen_m);
    end
    checks++;
    if ((obs !== 8'hA5) || (nvalid != 8)) begin
      failures++;
      $display("FAIL single_a5_stream got=%h/%0d bits exp=a5/8 bits", obs, nvalid);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] word;
    logic [3:0] got, exp;
    word = 8'hC1;
    @(negedge clk);
    bl.in_valid = 1'b1;
    bl.in_data  = word;
    sen_l       = 1'b1;
    #1;
    checks++;
    if (bl.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL lsb_accept_ready got=%b exp=1", bl.in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bl.in_valid = 1'b0;
      bl.in_data  = 8'($urandom);
      #1;
      got = {bl.ser_valid, bl.ser_out, bl.ser_first, bl.ser_last};
      exp = {1'b1, word[i], (i == 0), (i == 7)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL lsb_bit%0d got(v,o,f,l)=%b exp=%b", i, got, exp);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bl.ser_valid, bl.in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL lsb_end got(v,r)=%b exp=01", {bl.ser_valid, bl.in_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, exp;
    int nvalid, nready;
    nvalid = 0;
    nready = 0;
    for (int i = 0; i < 19; i++) begin
      drive_main(i <= 8, (i == 0) ? 8'hFF : 8'h00, 1'b1);
      got = {bm.ser_valid, bm.ser_out, bm.ser_first, bm.ser_last, bm.in_ready};
      exp = m_expect(sen_m);
      checks++;
      if ((got & m_mask(exp)) !== exp) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got(v,o,f,l,r)=%b exp=%b", i, got, exp);
      end
      if ((i >= 1) && (i <= 16) && (bm.ser_valid === 1'b1)) nvalid++;
      if ((i >= 1) && (i <= 8) && (bm.in_ready === 1'b1)) nready++;
      m_edge(bm.in_valid, bm.in_data, sen_m);
    end
    checks++;
    if ((nvalid != 16) || (nready != 1)) begin
      failures++;
      $display("FAIL back_to_back_frame got valid=%0d ready=%0d exp valid=16 ready=1",
               nvalid, nready);
    end
  endtask

  task automatic test_stall();
    logic [4:0] got, exp;
    int nready;
    nready = 0;
    drive_main(1'b1, 8'($urandom), 1'b1);
    got = {bm.ser_valid, bm.ser_out, bm.ser_first, bm.ser_last, bm.in_ready};
    exp = m_expect(sen_m);
    checks++;
    if ((got & m_mask(exp)) !== exp) begin
      failures++;
      $display("FAIL stall_accept got=%b exp=%b", got, exp);
    end
    m_edge(bm.in_valid, bm.in_data, sen_m);
    for (int i = 0; i < 26; i++) begin
      if (i < 16) drive_main(1'b1, 8'($urandom), (i % 2) == 1);
      else        drive_main(1'b0, 8'($urandom), 1'b1);
      got = {bm.ser_valid, bm.ser_out, bm.ser_first, bm.ser_last, bm.in_ready};
      exp = m_expect(sen_m);
      checks++;
      if ((got & m_mask(exp)) !== exp) begin
        failures++;
        $display("FAIL stall cyc=%0d got(v,o,f,l,r)=%b exp=%b", i, got, exp);
      end
      if ((i < 15) && (bm.in_ready === 1'b1)) nready++;
      m_edge(bm.in_valid, bm.in_data, sen_m);
    end
    checks++;
    if (nready != 0) begin
      failures++;
      $display("FAIL stall_midword_ready got=%0d exp=0", nready);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [4:0] got, exp;
    logic [7:0] obs;
    for (int i = 0; i < 4; i++) begin
      drive_main(i == 0, 8'($urandom), 1'b1);
      got = {bm.ser_valid, bm.ser_out, bm.ser_first, bm.ser_last, bm.in_ready};
      exp = m_expect(sen_m);
      checks++;
      if ((got & m_mask(exp)) !== exp) begin
        failures++;
        $display("FAIL rst_mid_pre cyc=%0d got=%b exp=%b", i, got, exp);
      end
      if (i < 3) m_edge(bm.in_valid, bm.in_data, sen_m);
    end
    // Third bit is now on the line; reset between clock edges.
    rst = 1'b0;
    #1;
    got = {bm.ser_valid, bm.ser_out, bm.ser_first, bm.ser_last, bm.in_ready};
    checks++;
    if (got !== 5'b00000) begin
      failures++;
      $display("FAIL rst_mid_async got=%b exp=00000", got);
    end
    m_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bm.ser_valid, bm.in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL rst_mid_release got(v,r)=%b exp=01", {bm.ser_valid, bm.in_ready});
    end
    obs = '0;
    for (int i = 0; i < 10; i++) begin
      drive_main(i == 0, (i == 0) ? 8'h81 : 8'($urandom), 1'b1);
      got = {bm.ser_valid, bm.ser_out, bm.ser_first, bm.ser_last, bm.in_ready};
      exp = m_expect(sen_m);
      checks++;
      if ((got & m_mask(exp)) !== exp) begin
        failures++;
        $display("FAIL rst_mid_post cyc=%0d got=%b exp=%b", i, got, exp);
      end
      if (bm.ser_valid === 1'b1) obs = {obs[6:0], bm.ser_out};
      m_edge(bm.in_valid, bm.in_data, sen_m);
    end
    checks++;
    if (obs !== 8'h81) begin
      failures++;
      $display("FAIL rst_mid_word got=%h exp=81", obs);
    end
  endtask

  task automatic test_random();
    logic [4:0] got, exp;
    for (int i = 0; i < 410; i++) begin
      if (i < 400) drive_main($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)));
      else         drive_main(1'b0, 8'($urandom), 1'b1);
      got = {bm.ser_valid, bm.ser_out, bm.ser_first, bm.ser_last, bm.in_ready};
      exp = m_expect(sen_m);
      checks++;
      if ((got & m_mask(exp)) !== exp) begin
        failures++;
        $display("FAIL random cyc=%0d got(v,o,f,l,r)=%b exp=%b", i, got, exp);
      end
      m_edge(bm.in_valid, bm.in_data, sen_m);
    end
  endtask

  task automatic test_n1();
    logic [2:0] seq;
    logic [4:0] got, exp;
    seq = 3'b101;
    @(negedge clk);
    b1.in_valid = 1'b1;
    b1.in_data  = seq[0];
    sen_1       = 1'b1;
    #1;
    checks++;
    if ({b1.ser_valid, b1.in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL n1_idle got(v,r)=%b exp=01", {b1.ser_valid, b1.in_ready});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b1.in_valid = (i < 2);
      b1.in_data  = (i < 2) ? seq[i+1] : 1'b0;
      #1;
      got = {b1.ser_valid, b1.ser_out, b1.ser_first, b1.ser_last, b1.in_ready};
      exp = {1'b1, seq[i], 1'b1, 1'b1, 1'b1};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL n1_bit%0d got(v,o,f,l,r)=%b exp=%b", i, got, exp);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({b1.ser_valid, b1.in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL n1_end got(v,r)=%b exp=01", {b1.ser_valid, b1.in_ready});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst         = 1'b0;
    sen_m       = 1'b0;
    sen_l       = 1'b0;
    sen_1       = 1'b0;
    bm.in_valid = 1'b0;
    bm.in_data  = '0;
    bl.in_valid = 1'b0;
    bl.in_data  = '0;
    b1.in_valid = 1'b0;
    b1.in_data  = '0;

    test_reset();
    test_single_a5();
    test_lsb_first();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_random();
    test_n1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/n_bit_piso_serializer.md
Name: n_bit_piso_serializer

Overview:
- Parallel-in, serial-out shift register. Accepts an N-bit word over a valid/ready handshake and emits it one bit per enabled cycle on a serial line.
- Provides first-bit and last-bit framing strobes.
- Transmit-side counterpart to the team's serial-in, parallel-out capture registers. Sits between word-wide datapath logic and a bit-serial link paced by an external bit-rate enable.

Parameters:
- N, 8, word width in bits; legal range N >= 1.
- MSB_FIRST, 1, 1 = bit N-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset; clears all state immediately.
- shift_en  input  1  bit-rate enable; the serial output advances only at edges where this is 1.
- in_valid  input  1  in_data is presented for transfer.
- in_data  input  N  word to serialise; sampled only on handshake.
- in_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a word bit.
- ser_first  output  1  ser_out is the first bit of a word.
- ser_last  output  1  ser_out is the last bit of a word.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, bit counter=0, ser_out=0, ser_valid=0, ser_first=0, ser_last=0. in_ready=1 whenever rst=1 and state=IDLE.
- States: IDLE and SHIFT.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture in_data, load counter=N-1, go to SHIFT.
  - Acceptance does not depend on shift_en.
- SHIFT:
  - ser_valid=1. ser_out = shift-register bit selected by MSB_FIRST.
  - ser_first=1 while counter=N-1. ser_last=1 while counter=0.
  - On an edge with shift_en=1 and counter>0: shift by one toward the output end, decrement counter.
  - On an edge with shift_en=0: everything holds.
- Latency: first bit is visible on ser_out in the cycle after the accepting edge, regardless of shift_en. Each bit stays visible until an edge with shift_en=1.
- End of word: at an edge with shift_en=1 and counter=0:
  - If in_valid=1, load the new word and stay in SHIFT. ser_first=1 next cycle, with no idle gap.
  - Otherwise go to IDLE and drop ser_valid.
- in_ready in SHIFT equals (counter==0 && shift_en). This is a combinational path from shift_en, and is the only combinational input-to-output path.
- Back-to-back words produce a contiguous bit stream when shift_en is held at 1.
- in_data changing without a handshake has no effect.
- N=1: ser_first and ser_last are both 1 on the single bit; counter width is 1.
- Counter width is max(1, clog2(N)) bits. The counter never wraps below 0.
- Reset mid-word: the word is discarded, with no partial completion. After rst deasserts, the block is in IDLE with in_ready=1.
- Simultaneous in_valid and shift_en while mid-word (counter>0): in_ready=0, the word is not accepted, and the shift proceeds.

Decomposition:
- Shared package shift_reg_pkg:
  - piso_state_t enum {IDLE, SHIFT}.
  - Function for the counter width: max(1, clog2(N)).
- One natural sub-module: piso_bit_counter. It is a loadable down-counter with enable, asynchronous active-low rst, and a zero flag. The top level holds the FSM, the shift register and the output strobes.

Test Plan:
- N=8, MSB_FIRST=1, shift_en=1, single 8'hA5 → ser_out 1,0,1,0,0,1,0,1 on cycles 1..8 after accept. ser_first only on cycle 1, ser_last only on cycle 8, then ser_valid=0 and in_ready=1.
- MSB_FIRST=0, 8'hC1 → ser_out 1,0,0,0,0,0,1,1.
- Back-to-back: in_valid held with 8'hFF then 8'h00, shift_en=1 → 16 contiguous bits (8 ones, then 8 zeros). in_ready=1 only on the last-bit cycle of the first word. ser_valid never drops.
- Stall: shift_en alternating 1,0 → each bit held 2 cycles, 16 cycles per word. in_valid during mid-word cycles is not accepted (in_ready=0).
- Reset mid-word: drive rst=0 while the 3rd bit is shown → all outputs 0 immediately. After release, in_ready=1. A new word 8'h81 is sent cleanly: 1,0,0,0,0,0,0,1.
- N=1: words 1,0,1 back-to-back → ser_out 1,0,1 with ser_first=ser_last=1 on every cycle.
